spi_host_master: RTL and testbench
==================================

Name: spi_host_master

Overview:
- System-clock-domain SPI host that drives the AES/LDO SPI slave port (sclk, mosi, csel_AES, csel_LDO, miso).
- Serialises a 131-bit AES frame {valid, data[127:0], encrypt, is_key}, MSB first. Serialises a 16-bit LDO frame {4'b0, P, I, D}, MSB first.
- During AES frames, captures the 131-bit miso response and unpacks it into data, encrypt and valid fields.
- Sits between the on-chip test/config controller and the SPI pads.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period; legal range 2..255.
- CS_GAP, 2, idle clk cycles after a chip select drops before busy clears; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- aes_start  in  1  one-cycle request to send an AES frame
- aes_tx_valid  in  1  frame bit 130
- aes_tx_data  in  128  frame bits 129:2
- aes_tx_encrypt  in  1  frame bit 1
- aes_tx_is_key  in  1  frame bit 0
- ldo_start  in  1  one-cycle request to send an LDO frame
- ldo_P  in  4  PID P gain
- ldo_I  in  4  PID I gain
- ldo_D  in  4  PID D gain
- busy  out  1  high while a frame or its gap is in progress
- done  out  1  one-cycle pulse when busy falls
- aes_rx_data  out  128  captured miso data
- aes_rx_encrypt  out  1  captured encrypt bit
- aes_rx_valid  out  1  captured valid bit
- aes_rx_strobe  out  1  one-cycle pulse when the aes_rx_* outputs update
- sclk  out  1  SPI clock; idles low
- mosi  out  1  SPI data to slave
- csel_AES  out  1  active-high AES chip select
- csel_LDO  out  1  active-high LDO chip select
- miso  in  1  SPI data from slave

Behaviour:
- Reset values: sclk=0, mosi=0, csel_AES=0, csel_LDO=0, busy=0, done=0, aes_rx_*=0, aes_rx_strobe=0. FSM goes to IDLE. Reset mid-frame aborts the frame immediately: chip select drops in the next cycle and no done pulse is issued.
- FSM states: IDLE, SETUP, HIGH, LOW, GAP.
- IDLE:
  - On aes_start, latch the 131-bit tx word and select AES.
  - Otherwise, on ldo_start, latch {4'b0,P,I,D} and select LDO. AES wins a simultaneous request; the LDO request is dropped.
  - busy=1 the cycle after the start. Starts while busy are ignored.
- SETUP:
  - Selected csel=1, mosi=first (MSB) bit, sclk=0.
  - Lasts CLK_DIV cycles, then goes to HIGH.
- HIGH:
  - sclk=1 for CLK_DIV cycles; the slave samples mosi on this rising edge.
  - Then goes to LOW.
- LOW:
  - On entry, sclk=0 and miso is sampled (the value present on the high-to-low transition).
  - If bits remain, mosi advances to the next bit on entry.
  - After CLK_DIV cycles: goes to HIGH if bits remain. Otherwise drops csel and mosi=0, then goes to GAP.
- Bit counts: AES frame = exactly 131 rising edges; LDO frame = exactly 16. An exact count keeps the slave's modulo-131 read index aligned across frames.
- csel high time: AES = 263*CLK_DIV cycles; LDO = 33*CLK_DIV cycles.
- GAP: CS_GAP cycles, then IDLE with busy=0 and done=1 for one cycle.
- Receive ordering (AES only):
  - The n-th sample (n=0..130) is slave word bit n.
  - Bit 0 is discarded (always 0).
  - Bit 1 goes to aes_rx_encrypt.
  - Bits 2..129 go to aes_rx_data[0..127].
  - Bit 130 goes to aes_rx_valid.
- Receive update: outputs update together with a one-cycle aes_rx_strobe on the cycle csel_AES falls. They hold until the next AES frame completes.
- LDO frames do not touch the aes_rx_* outputs. miso is ignored during LDO frames.
- csel_AES and csel_LDO are never high simultaneously.

Optional Feature:
- SPI_PENDING_EN.
- Defined:
  - A start arriving while busy is latched as a one-deep pending request, one per target.
  - On return to IDLE the pending request issues after the done pulse, with AES priority.
  - A second start to an already-pending target overwrites its payload.
- Undefined: starts while busy are ignored. Behaviour is otherwise identical.

Test Plan:
- CLK_DIV=4; AES start with valid=1, data=128'h000102...0F, encrypt=1, is_key=0 → slave model receives 131'h{1,data,1,0}; csel_AES high 1052 cycles; done 2 cycles after it falls.
- Slave model returns out word with data=128'hDEADBEEF...CAFE, encrypt=0, valid=1 → aes_rx_data matches, aes_rx_encrypt=0, aes_rx_valid=1, aes_rx_strobe pulses once.
- LDO start with P=4'hA, I=4'h5, D=4'h3 → 16 bits 16'h0A53 on mosi, 16 sclk rising edges, csel_LDO high 132 cycles, aes_rx_* unchanged.
- aes_start and ldo_start in the same cycle → only the AES frame is sent; without SPI_PENDING_EN, no LDO frame follows. With it, the LDO frame follows the done pulse.
- Two back-to-back AES frames → second response is bit-aligned (slave index wrap verified); reset asserted at bit 60 → csel_AES=0 next cycle, busy=0, no done pulse.

Source files
------------

// File: rtl/spi_host_master.sv
// spi_host_master
// System-clock-domain SPI host for the AES/LDO slave port.
// Serialises a 131-bit AES frame {valid, data[127:0], encrypt, is_key} or a
// 16-bit LDO frame {4'b0, P, I, D}, MSB first. During AES frames it also
// collects the 131-bit miso response and unpacks it into the aes_rx_* outputs.
//
// Parameters:
//   CLK_DIV  clk cycles per sclk half-period (2..255)
//   CS_GAP   idle clk cycles after chip select drops before busy clears (1..255)
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   aes_start, aes_tx_*         AES frame request and payload
//   ldo_start, ldo_P/I/D        LDO frame request and PID gains
//   busy, done                  frame-in-progress flag, one-cycle completion pulse
//   aes_rx_data/encrypt/valid   unpacked AES response
//   aes_rx_strobe               one-cycle pulse when aes_rx_* update
//   sclk, mosi, csel_AES,
//   csel_LDO, miso              SPI pads
//
// Optional feature macro: SPI_PENDING_EN
//   When defined, a start arriving while busy is held as a one-deep pending
//   request per target and issued after the done pulse (AES first).
//   When undefined, starts while busy are ignored.
module spi_host_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         aes_start,
    input  logic         aes_tx_valid,
    input  logic [127:0] aes_tx_data,
    input  logic         aes_tx_encrypt,
    input  logic         aes_tx_is_key,
    input  logic         ldo_start,
    input  logic [3:0]   ldo_P,
    input  logic [3:0]   ldo_I,
    input  logic [3:0]   ldo_D,
    output logic         busy,
    output logic         done,
    output logic [127:0] aes_rx_data,
    output logic         aes_rx_encrypt,
    output logic         aes_rx_valid,
    output logic         aes_rx_strobe,
    output logic         sclk,
    output logic         mosi,
    output logic         csel_AES,
    output logic         csel_LDO,
    input  logic         miso
);

    localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_M1   = 8'(CS_GAP - 1);
    localparam logic [7:0] AES_BITS = 8'd131;
    localparam logic [7:0] LDO_BITS = 8'd16;

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

    state_t         state_q;
    logic [7:0]     cnt_q;
    logic [7:0]     bits_q;
    logic [129:0]   tx_q;       // bits still to send after the one on mosi
    logic [129:0]   rx_q;       // samples 1..130; sample 0 falls off the end
    logic           sel_aes_q;
    logic           busy_q, done_q, strobe_q, sclk_q, mosi_q, cs_aes_q, cs_ldo_q;
    logic [127:0]   rx_data_q;
    logic           rx_enc_q, rx_vld_q;

    logic [130:0]   aes_word_d;
    logic           aes_req, ldo_req;
    logic [130:0]   aes_req_word;
    logic [11:0]    ldo_req_pid;
    logic [130:0]   ldo_word_d;

    assign aes_word_d = {aes_tx_valid, aes_tx_data, aes_tx_encrypt, aes_tx_is_key};

`ifdef SPI_PENDING_EN
    logic           pend_aes_q, pend_ldo_q;
    logic [130:0]   pend_aes_word_q;
    logic [11:0]    pend_ldo_pid_q;
    logic           idle_ldo_launch;

    assign aes_req      = aes_start | pend_aes_q;
    assign aes_req_word = aes_start ? aes_word_d : pend_aes_word_q;
    assign ldo_req      = ldo_start | pend_ldo_q;
    assign ldo_req_pid  = ldo_start ? {ldo_P, ldo_I, ldo_D} : pend_ldo_pid_q;
    // LDO only launches from IDLE when no AES request competes; otherwise it waits.
    assign idle_ldo_launch = (state_q == IDLE) && !aes_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_aes_q <= 1'b0;
            pend_ldo_q <= 1'b0;
        end else begin
            if (aes_start && state_q != IDLE) begin
                pend_aes_q      <= 1'b1;
                pend_aes_word_q <= aes_word_d;
            end else if (state_q == IDLE) begin
                pend_aes_q <= 1'b0;
            end
            if (ldo_start && !idle_ldo_launch) begin
                pend_ldo_q     <= 1'b1;
                pend_ldo_pid_q <= {ldo_P, ldo_I, ldo_D};
            end else if (idle_ldo_launch) begin
                pend_ldo_q <= 1'b0;
            end
        end
    end
`else
    assign aes_req      = aes_start;
    assign aes_req_word = aes_word_d;
    assign ldo_req      = ldo_start;
    assign ldo_req_pid  = {ldo_P, ldo_I, ldo_D};
`endif

    // LDO word is left-justified so both frames shift out of the same MSB.
    assign ldo_word_d = {4'b0000, ldo_req_pid, 115'd0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bits_q    <= '0;
            sel_aes_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            strobe_q  <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_aes_q  <= 1'b0;
            cs_ldo_q  <= 1'b0;
            rx_data_q <= '0;
            rx_enc_q  <= 1'b0;
            rx_vld_q  <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (aes_req) begin
                        mosi_q    <= aes_req_word[130];
                        tx_q      <= aes_req_word[129:0];
                        bits_q    <= AES_BITS;
                        sel_aes_q <= 1'b1;
                        cs_aes_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        cnt_q     <= DIV_M1;
                        state_q   <= SETUP;
                    end else if (ldo_req) begin
                        mosi_q    <= ldo_word_d[130];
                        tx_q      <= ldo_word_d[129:0];
                        bits_q    <= LDO_BITS;
                        sel_aes_q <= 1'b0;
                        cs_ldo_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        cnt_q     <= DIV_M1;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == 8'd0) begin
                        sclk_q  <= 1'b1;
                        cnt_q   <= DIV_M1;
                        state_q <= HIGH;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                HIGH: begin
                    if (cnt_q == 8'd0) begin
                        // Falling edge: take miso, then present the next bit.
                        sclk_q  <= 1'b0;
                        cnt_q   <= DIV_M1;
                        bits_q  <= bits_q - 8'd1;
                        state_q <= LOW;
                        if (sel_aes_q) begin
                            rx_q <= {miso, rx_q[129:1]};
                        end
                        if (bits_q != 8'd1) begin
                            mosi_q <= tx_q[129];
                            tx_q   <= {tx_q[128:0], 1'b0};
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                LOW: begin
                    if (cnt_q == 8'd0) begin
                        if (bits_q != 8'd0) begin
                            sclk_q  <= 1'b1;
                            cnt_q   <= DIV_M1;
                            state_q <= HIGH;
                        end else begin
                            cs_aes_q <= 1'b0;
                            cs_ldo_q <= 1'b0;
                            mosi_q   <= 1'b0;
                            cnt_q    <= GAP_M1;
                            state_q  <= GAP;
                            if (sel_aes_q) begin
                                rx_enc_q  <= rx_q[0];
                                rx_data_q <= rx_q[128:1];
                                rx_vld_q  <= rx_q[129];
                                strobe_q  <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == 8'd0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign aes_rx_data    = rx_data_q;
    assign aes_rx_encrypt = rx_enc_q;
    assign aes_rx_valid   = rx_vld_q;
    assign aes_rx_strobe  = strobe_q;
    assign sclk           = sclk_q;
    assign mosi           = mosi_q;
    assign csel_AES       = cs_aes_q;
    assign csel_LDO       = cs_ldo_q;

endmodule

// File: tb/tb_spi_host_master.sv
// Directed bench for spi_host_master (CLK_DIV=4, CS_GAP=2) with a behavioural
// SPI slave that keeps a free-running modulo-131 bit index across AES frames.
module tb_spi_host_master;

    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         aes_start = 1'b0;
    logic         aes_tx_valid = 1'b0;
    logic [127:0] aes_tx_data = '0;
    logic         aes_tx_encrypt = 1'b0;
    logic         aes_tx_is_key = 1'b0;
    logic         ldo_start = 1'b0;
    logic [3:0]   ldo_P = '0, ldo_I = '0, ldo_D = '0;
    logic         busy, done, aes_rx_encrypt, aes_rx_valid, aes_rx_strobe;
    logic [127:0] aes_rx_data;
    logic         sclk, mosi, csel_AES, csel_LDO;
    logic         miso = 1'b0;

    always #5 clk = ~clk;

    spi_host_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .reset(reset),
        .aes_start(aes_start), .aes_tx_valid(aes_tx_valid), .aes_tx_data(aes_tx_data),
        .aes_tx_encrypt(aes_tx_encrypt), .aes_tx_is_key(aes_tx_is_key),
        .ldo_start(ldo_start), .ldo_P(ldo_P), .ldo_I(ldo_I), .ldo_D(ldo_D),
        .busy(busy), .done(done),
        .aes_rx_data(aes_rx_data), .aes_rx_encrypt(aes_rx_encrypt),
        .aes_rx_valid(aes_rx_valid), .aes_rx_strobe(aes_rx_strobe),
        .sclk(sclk), .mosi(mosi), .csel_AES(csel_AES), .csel_LDO(csel_LDO), .miso(miso)
    );

    // ---------------- slave model ----------------
    logic [130:0] sl_out = '0;     // word returned by the slave, bit n on the n-th edge
    logic [130:0] sl_rx  = '0;     // last 131 bits seen on mosi (AES)
    logic [15:0]  ldo_rx = '0;     // last 16 bits seen on mosi (LDO)
    int           sl_idx = 0;
    int           aes_rises = 0, ldo_rises = 0;

    always @(posedge sclk) begin
        if (csel_AES) begin
            sl_rx = {sl_rx[129:0], mosi};
            miso  = sl_out[sl_idx];
            sl_idx = (sl_idx == 130) ? 0 : sl_idx + 1;
            aes_rises++;
        end
        if (csel_LDO) begin
            ldo_rx = {ldo_rx[14:0], mosi};
            ldo_rises++;
        end
    end

    // ---------------- monitors (monotonic counters) ----------------
    int   cyc = 0;
    int   aes_cs_cyc = 0, ldo_cs_cyc = 0, done_cnt = 0, strobe_cnt = 0, both_hi = 0;
    int   aes_frames = 0, ldo_frames = 0, fall_cyc = 0, done_cyc = 0;
    logic prev_aes = 1'b0, prev_ldo = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (csel_AES) aes_cs_cyc++;
        if (csel_LDO) ldo_cs_cyc++;
        if (csel_AES && csel_LDO) both_hi++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (aes_rx_strobe) strobe_cnt++;
        if (csel_AES && !prev_aes) aes_frames++;
        if (csel_LDO && !prev_ldo) ldo_frames++;
        if (prev_aes && !csel_AES) fall_cyc = cyc;
        prev_aes = csel_AES;
        prev_ldo = csel_LDO;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [130:0] got, input logic [130:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_aes(input logic v, input logic [127:0] d, input logic e, input logic k);
        @(negedge clk);
        aes_tx_valid = v; aes_tx_data = d; aes_tx_encrypt = e; aes_tx_is_key = k;
        aes_start = 1'b1;
        @(negedge clk);
        aes_start = 1'b0;
    endtask

    task automatic pulse_ldo(input logic [3:0] p, input logic [3:0] i, input logic [3:0] d);
        @(negedge clk);
        ldo_P = p; ldo_I = i; ldo_D = d;
        ldo_start = 1'b1;
        @(negedge clk);
        ldo_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    int           s_aes_cyc, s_ldo_cyc, s_done, s_strobe, s_aes_r, s_ldo_r, s_aes_f, s_ldo_f;
    logic [127:0] d_rx;
    logic [130:0] exp_w;

    task automatic snap();
        s_aes_cyc = aes_cs_cyc; s_ldo_cyc = ldo_cs_cyc; s_done = done_cnt;
        s_strobe = strobe_cnt; s_aes_r = aes_rises; s_ldo_r = ldo_rises;
        s_aes_f = aes_frames; s_ldo_f = ldo_frames;
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_cs", {csel_AES, csel_LDO}, 2'b00);
        chk("rst_busy_done", {busy, done}, 2'b00);
        chk("rst_rx", {aes_rx_valid, aes_rx_encrypt, aes_rx_strobe, aes_rx_data}, '0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // AES frame 1
        d_rx   = 128'hDEADBEEF0123456789ABCDEF0000CAFE;
        sl_out = {1'b1, d_rx, 1'b0, 1'b0};
        snap();
        pulse_aes(1'b1, 128'h000102030405060708090A0B0C0D0E0F, 1'b1, 1'b0);
        chk("aes1_busy_after_start", busy, 1'b1);
        chk("aes1_cs_after_start", csel_AES, 1'b1);
        wait_idle("aes1_finish", 1200);
        chk("aes1_mosi_word", sl_rx, {1'b1, 128'h000102030405060708090A0B0C0D0E0F, 1'b1, 1'b0});
        chk("aes1_rises", aes_rises - s_aes_r, 131);
        chk("aes1_cs_cycles", aes_cs_cyc - s_aes_cyc, 1052);
        chk("aes1_done_lat", done_cyc - fall_cyc, CS_GAP);
        chk("aes1_done_cnt", done_cnt - s_done, 1);
        chk("aes1_rx_data", aes_rx_data, d_rx);
        chk("aes1_rx_enc", aes_rx_encrypt, 1'b0);
        chk("aes1_rx_valid", aes_rx_valid, 1'b1);
        chk("aes1_strobe_cnt", strobe_cnt - s_strobe, 1);

        // LDO frame
        snap();
        pulse_ldo(4'hA, 4'h5, 4'h3);
        wait_idle("ldo_finish", 300);
        chk("ldo_word", ldo_rx, 16'h0A53);
        chk("ldo_rises", ldo_rises - s_ldo_r, 16);
        chk("ldo_cs_cycles", ldo_cs_cyc - s_ldo_cyc, 132);
        chk("ldo_rx_data_kept", aes_rx_data, d_rx);
        chk("ldo_rx_flags_kept", {aes_rx_valid, aes_rx_encrypt}, 2'b10);
        chk("ldo_no_strobe", strobe_cnt - s_strobe, 0);
        chk("ldo_no_aes_rises", aes_rises - s_aes_r, 0);

        // simultaneous AES + LDO start
        d_rx   = 128'h55555555AAAAAAAA0F0F0F0FF0F0F0F0;
        sl_out = {1'b0, d_rx, 1'b1, 1'b0};
        snap();
        @(negedge clk);
        aes_tx_valid = 1'b0; aes_tx_data = 128'h0123456789ABCDEFFEDCBA9876543210;
        aes_tx_encrypt = 1'b0; aes_tx_is_key = 1'b1;
        ldo_P = 4'h1; ldo_I = 4'h2; ldo_D = 4'h3;
        aes_start = 1'b1; ldo_start = 1'b1;
        @(negedge clk);
        aes_start = 1'b0; ldo_start = 1'b0;
        chk("both_aes_first", {csel_AES, csel_LDO}, 2'b10);
        wait_idle("both_aes_finish", 1200);
        repeat (300) @(negedge clk);
        wait_idle("both_tail_finish", 300);
        chk("both_aes_frames", aes_frames - s_aes_f, 1);
        chk("both_aes_word", sl_rx, {1'b0, 128'h0123456789ABCDEFFEDCBA9876543210, 1'b0, 1'b1});
        chk("both_rx_data", aes_rx_data, d_rx);
        chk("both_rx_flags", {aes_rx_valid, aes_rx_encrypt}, 2'b01);
`ifdef SPI_PENDING_EN
        chk("both_ldo_frames", ldo_frames - s_ldo_f, 1);
        chk("both_ldo_word", ldo_rx, 16'h0123);
`else
        chk("both_ldo_frames", ldo_frames - s_ldo_f, 0);
`endif

        // back-to-back AES: slave index must still line up
        d_rx   = 128'hFEDCBA98765432100123456789ABCDEF;
        sl_out = {1'b1, d_rx, 1'b1, 1'b0};
        snap();
        pulse_aes(1'b1, 128'hFFFF0000FFFF0000FFFF0000FFFF0000, 1'b0, 1'b1);
        wait_idle("b2b_finish", 1200);
        chk("b2b_word", sl_rx, {1'b1, 128'hFFFF0000FFFF0000FFFF0000FFFF0000, 1'b0, 1'b1});
        chk("b2b_rx_data", aes_rx_data, d_rx);
        chk("b2b_rx_flags", {aes_rx_valid, aes_rx_encrypt}, 2'b11);
        chk("b2b_strobe_cnt", strobe_cnt - s_strobe, 1);
        chk("b2b_slave_idx", sl_idx, 0);

        // reset in the middle of a frame
        snap();
        pulse_aes(1'b1, 128'h1, 1'b1, 1'b1);
        begin
            int n;
            n = 0;
            while ((aes_rises - s_aes_r) < 60 && n < 1000) begin
                @(negedge clk);
                n++;
            end
        end
        chk("abort_reached_bit60", aes_rises - s_aes_r, 60);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_cs", csel_AES, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rx_cleared", aes_rx_valid, 1'b0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", done_cnt - s_done, 0);
        chk("abort_no_strobe", strobe_cnt - s_strobe, 0);
        chk("never_both_cs", both_hi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
